// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter: round-robin packet arbiter driving fifo_sel_bits for one cross-bar output FIFO.
// Define ARB_TIMEOUT_EN to add a stall watchdog that force-releases a hung grant after TIMEOUT cycles.
module fifo_port_arbiter #(
    parameter int PORT_NUM = 4,
    parameter int CNT_W    = 16,
    parameter int BEAT_W   = 12
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 1024
`endif
) (
    input  logic                glb_clk,
    input  logic                glb_areset_n,
    input  logic                arb_en,
    input  logic [PORT_NUM-1:0] port_req,
    input  logic                obs_tvalid,
    input  logic                obs_tready,
    input  logic                obs_tlast,
    output logic [PORT_NUM-1:0] fifo_sel_bits,
    output logic                grant_active,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [BEAT_W-1:0]   beat_cnt,
    output logic                timeout_err
);
    localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PORT_NUM-1:0] sel_q, sel_d;
    logic                grant_q, grant_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [CNT_W-1:0]    pkt_q, pkt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                tout_q, tout_d;
    logic                beat;

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [STALL_W-1:0]  stall_q, stall_d;
`endif

    function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] v);
        return (&v) ? v : v + BEAT_W'(1);
    endfunction

    function automatic logic [PORT_NUM-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [PORT_NUM-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        return PTR_W'((int'(base) + off) % PORT_NUM);
    endfunction

    assign beat = obs_tvalid & obs_tready;

    // Search starts just above the last served port so it drops to lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            if (!pick_valid && port_req[wrap_idx(rr_q, i)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_idx(rr_q, i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        win_d   = win_q;
        pkt_d   = pkt_q;
        beat_d  = beat_q;
        tout_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        stall_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (arb_en && pick_valid) begin
                    state_d = START;
                    win_d   = pick_idx;
                    sel_d   = onehot(pick_idx);
                    grant_d = 1'b1;
                    beat_d  = '0;
                end
            end
            START, BUSY: begin
                // A request withdrawn before any data moved is dropped without a turn being consumed.
                if (state_q == START && !port_req[win_q]) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    grant_d = 1'b0;
                end else if (beat) begin
                    beat_d = sat_inc(beat_q);
                    if (obs_tlast) begin
                        state_d = IDLE;
                        sel_d   = '0;
                        grant_d = 1'b0;
                        rr_d    = win_q;
                        pkt_d   = pkt_q + CNT_W'(1);
                    end else begin
                        state_d = BUSY;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    grant_d = 1'b0;
                    rr_d    = win_q;
                    tout_d  = 1'b1;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                grant_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge glb_clk) begin
        if (!glb_areset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            grant_q <= 1'b0;
            rr_q    <= PTR_W'(PORT_NUM - 1);
            win_q   <= '0;
            pkt_q   <= '0;
            beat_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            pkt_q   <= pkt_d;
            beat_q  <= beat_d;
            tout_q  <= tout_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge glb_clk) begin
        if (!glb_areset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    assign fifo_sel_bits = sel_q;
    assign grant_active  = grant_q;
    assign pkt_cnt       = pkt_q;
    assign beat_cnt      = beat_q;
    assign timeout_err   = tout_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter: vector table plus round-robin, saturation and watchdog sequences.
module tb_fifo_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_en;
    logic [3:0]  port_req;
    logic        obs_tvalid;
    logic        obs_tready;
    logic        obs_tlast;
    logic [3:0]  fifo_sel_bits;
    logic        grant_active;
    logic [15:0] pkt_cnt;
    logic [11:0] beat_cnt;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_port_arbiter #(
        .PORT_NUM(4),
        .CNT_W(16),
        .BEAT_W(12)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .glb_clk(clk),
        .glb_areset_n(rst_n),
        .arb_en(arb_en),
        .port_req(port_req),
        .obs_tvalid(obs_tvalid),
        .obs_tready(obs_tready),
        .obs_tlast(obs_tlast),
        .fifo_sel_bits(fifo_sel_bits),
        .grant_active(grant_active),
        .pkt_cnt(pkt_cnt),
        .beat_cnt(beat_cnt),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic        rn;
        logic        en;
        logic [3:0]  req;
        logic        v;
        logic        r;
        logic        l;
        logic [3:0]  sel;
        logic        ga;
        logic [15:0] pkt;
        logic [11:0] beat;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string tag, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", tag, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [3:0] sel, input logic ga,
                             input logic [15:0] pkt, input logic [11:0] beat, input logic to);
        check({tag, ".sel"}, idx, 32'(fifo_sel_bits), 32'(sel));
        check({tag, ".grant"}, idx, 32'(grant_active), 32'(ga));
        check({tag, ".pkt"}, idx, 32'(pkt_cnt), 32'(pkt));
        check({tag, ".beat"}, idx, 32'(beat_cnt), 32'(beat));
        check({tag, ".tout"}, idx, 32'(timeout_err), 32'(to));
    endtask

    task automatic drive(input logic rn, input logic en, input logic [3:0] req,
                         input logic v, input logic r, input logic l);
        @(negedge clk);
        rst_n      = rn;
        arb_en     = en;
        port_req   = req;
        obs_tvalid = v;
        obs_tready = r;
        obs_tlast  = l;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rst_n = 1'b0; arb_en = 1'b0; port_req = '0;
        obs_tvalid = 1'b0; obs_tready = 1'b0; obs_tlast = 1'b0;

        // rn en req v r l -> sel ga pkt beat
        vq.push_back('{1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 16'd0, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 16'd0, 12'd1});
        vq.push_back('{1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 16'd0, 12'd1});
        vq.push_back('{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 16'd0, 12'd2});
        vq.push_back('{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd1, 12'd3});
        vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd1, 12'd3});
        // abort before first beat keeps rr on port 2, so port 1 wins again over port 2
        vq.push_back('{1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 16'd1, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd1, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 16'd1, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd2, 12'd1});
        vq.push_back('{1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 16'd2, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd3, 12'd1});
        // arb_en dropped mid-packet
        vq.push_back('{1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 16'd3, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 16'd3, 12'd1});
        vq.push_back('{1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 16'd3, 12'd2});
        vq.push_back('{1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd4, 12'd3});
        vq.push_back('{1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd4, 12'd3});
        vq.push_back('{1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd4, 12'd3});
        vq.push_back('{1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 16'd4, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd5, 12'd1});
        // reset in the middle of a packet on port 3
        vq.push_back('{1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 16'd5, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, 16'd5, 12'd1});
        vq.push_back('{1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, 16'd5, 12'd2});
        vq.push_back('{1'b0, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd0, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 16'd0, 12'd0});
        vq.push_back('{1'b1, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd1, 12'd1});

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rn, vq[i].en, vq[i].req, vq[i].v, vq[i].r, vq[i].l);
            check_all("vec", i, vq[i].sel, vq[i].ga, vq[i].pkt, vq[i].beat, 1'b0);
        end

        // Round-robin with all ports requesting, single-beat packets
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drive(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        check_all("rr_reset", 0, 4'b0000, 1'b0, 16'd0, 12'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
            check_all("rr_grant", k, rr_exp[k], 1'b1, 16'(k), 12'd0, 1'b0);
            drive(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
            check_all("rr_done", k, 4'b0000, 1'b0, 16'(k + 1), 12'd1, 1'b0);
        end

        // Long packet on port 2: beat counter saturates at 4095
        drive(1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        check_all("sat_grant", 0, 4'b0100, 1'b1, 16'd5, 12'd0, 1'b0);
        for (int i = 0; i < 4100; i++) begin
            drive(1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0);
            if (i == 4093) check("sat_pre.beat", i, 32'(beat_cnt), 32'd4094);
        end
        check_all("sat_hold", 0, 4'b0100, 1'b1, 16'd5, 12'd4095, 1'b0);
        drive(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
        check_all("sat_last", 0, 4'b0000, 1'b0, 16'd6, 12'd4095, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Stalled grant on port 2 is force-released after 16 cycles
        drive(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        check_all("to_grant", 0, 4'b0100, 1'b1, 16'd0, 12'd0, 1'b0);
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        check_all("to_wait", 0, 4'b0100, 1'b1, 16'd0, 12'd0, 1'b0);
        drive(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
        check_all("to_fire", 0, 4'b0000, 1'b0, 16'd0, 12'd0, 1'b1);
        drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_all("to_pulse", 0, 4'b0000, 1'b0, 16'd0, 12'd0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
